// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - beat-serial dot-product accumulator sequencing an external lane multiplier
// Optional clamping accumulator: define MAC_SEQUENCER_SATURATE_EN (default build wraps modulo 2^ACC_W).
module mac_sequencer #(
    parameter int SIZE      = 4,
    parameter int SETS      = 4,
    parameter int MAX_BEATS = 16,
    parameter int ACC_W     = 2*SIZE+SETS
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SETS*SIZE-1:0]           in_a,
    input  logic [SETS*SIZE-1:0]           in_b,
    input  logic                           in_last,
    output logic                           mul_valid,
    input  logic                           mul_ready,
    output logic [SETS*SIZE-1:0]           mul_a,
    output logic [SETS*SIZE-1:0]           mul_b,
    input  logic [2*SIZE+SETS-1:0]         mul_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_W-1:0]               out_data,
    output logic [$clog2(MAX_BEATS+1)-1:0] out_beats,
    output logic                           out_trunc
);
    localparam int CW = $clog2(MAX_BEATS+1);

    typedef enum logic [1:0] {ACCEPT, COMPUTE, DONE} state_t;

    state_t                state;
    logic [SETS*SIZE-1:0]  a_q;
    logic [SETS*SIZE-1:0]  b_q;
    logic                  last_q;
    logic [ACC_W-1:0]      acc;
    logic [CW-1:0]         count;
    logic                  trunc;
    logic [ACC_W-1:0]      acc_next;
    logic [CW-1:0]         count_next;

`ifdef MAC_SEQUENCER_SATURATE_EN
    // One extra bit catches the carry; once clamped, further adds keep overflowing so acc stays pinned.
    logic [ACC_W:0] sum;
    always_comb begin
        sum      = {1'b0, acc} + (ACC_W+1)'(mul_out);
        acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end
`else
    always_comb begin
        acc_next = acc + ACC_W'(mul_out);
    end
`endif

    assign count_next = count + CW'(1);

    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign out_data  = acc;
    assign out_beats = count;
    assign out_trunc = trunc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ACCEPT;
            a_q       <= '0;
            b_q       <= '0;
            last_q    <= 1'b0;
            acc       <= '0;
            count     <= '0;
            trunc     <= 1'b0;
            in_ready  <= 1'b1;
            mul_valid <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            state     <= ACCEPT;
            acc       <= '0;
            count     <= '0;
            trunc     <= 1'b0;
            in_ready  <= 1'b1;
            mul_valid <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                ACCEPT: begin
                    if (in_valid) begin
                        a_q       <= in_a;
                        b_q       <= in_b;
                        last_q    <= in_last;
                        in_ready  <= 1'b0;
                        mul_valid <= 1'b1;
                        state     <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (mul_ready) begin
                        acc       <= acc_next;
                        count     <= count_next;
                        mul_valid <= 1'b0;
                        if (last_q || count_next == CW'(MAX_BEATS)) begin
                            trunc     <= !last_q;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            in_ready  <= 1'b1;
                            state     <= ACCEPT;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc       <= '0;
                        count     <= '0;
                        trunc     <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCEPT;
                    end
                end
                default: begin
                    state     <= ACCEPT;
                    in_ready  <= 1'b1;
                    mul_valid <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - directed self-checking bench for mac_sequencer (SIZE=4, SETS=4, MAX_BEATS=16, ACC_W=12)
module tb_mac_sequencer;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_last;
    logic        mul_valid;
    logic        mul_ready;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [11:0] mul_out;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [4:0]  out_beats;
    logic        out_trunc;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_trunc_data;

    mac_sequencer #(.SIZE(4), .SETS(4), .MAX_BEATS(16), .ACC_W(12)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_beats(out_beats), .out_trunc(out_trunc)
    );

    always #5 clock = ~clock;

    // Reference lane multiplier: sum of the four 4x4 lane products.
    always_comb begin
        mul_out = '0;
        for (int i = 0; i < 4; i++)
            mul_out = mul_out + ({8'b0, mul_a[i*4 +: 4]} * {8'b0, mul_b[i*4 +: 4]});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic last);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic complete();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
        mul_ready = 1'b1; out_ready = 1'b0;
`ifdef MAC_SEQUENCER_SATURATE_EN
        exp_trunc_data = 32'd4095;
`else
        exp_trunc_data = 32'd2112;
`endif
        tick();
        tick();
        check("rst_mul_valid", {31'b0, mul_valid}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_trunc", {31'b0, out_trunc}, 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_beats", 32'(out_beats), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        #3 reset_n = 1'b1;
        tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Single beat, then hold the result with out_ready low while in_valid is offered.
        send_beat(16'h8088, 16'h8808, 1'b1);
        check("b1_mul_valid", {31'b0, mul_valid}, 32'd1);
        check("b1_in_ready", {31'b0, in_ready}, 32'd0);
        check("b1_mul_a", 32'(mul_a), 32'h8088);
        tick();
        check("b1_out_valid", {31'b0, out_valid}, 32'd1);
        check("b1_out_data", 32'(out_data), 32'd128);
        check("b1_out_beats", 32'(out_beats), 32'd1);
        check("b1_out_trunc", {31'b0, out_trunc}, 32'd0);
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_out_data", 32'(out_data), 32'd128);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        complete();
        check("drain_out_valid", {31'b0, out_valid}, 32'd0);
        check("drain_in_ready", {31'b0, in_ready}, 32'd1);
        check("drain_out_data", 32'(out_data), 32'd0);

        // Two beats with multiplier backpressure on the first.
        mul_ready = 1'b0;
        send_beat(16'h1111, 16'h2222, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_mul_valid", {31'b0, mul_valid}, 32'd1);
            check("bp_mul_a", 32'(mul_a), 32'h1111);
            check("bp_mul_b", 32'(mul_b), 32'h2222);
            check("bp_beats", 32'(out_beats), 32'd0);
            tick();
        end
        mul_ready = 1'b1;
        tick();
        check("bp_partial_data", 32'(out_data), 32'd8);
        check("bp_partial_beats", 32'(out_beats), 32'd1);
        check("bp_partial_valid", {31'b0, out_valid}, 32'd0);
        send_beat(16'h1111, 16'h2222, 1'b1);
        tick();
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        check("bp_out_data", 32'(out_data), 32'd16);
        check("bp_out_beats", 32'(out_beats), 32'd2);
        complete();

        // Sixteen full-scale beats with no in_last: truncation at MAX_BEATS.
        for (int i = 0; i < 16; i++) begin
            send_beat(16'hFFFF, 16'hFFFF, 1'b0);
            tick();
        end
        check("tr_out_valid", {31'b0, out_valid}, 32'd1);
        check("tr_out_trunc", {31'b0, out_trunc}, 32'd1);
        check("tr_out_beats", 32'(out_beats), 32'd16);
        check("tr_out_data", 32'(out_data), exp_trunc_data);
        complete();
        check("tr_trunc_cleared", {31'b0, out_trunc}, 32'd0);

        // Abort after two beats, then a fresh one-beat product.
        send_beat(16'h2222, 16'h3333, 1'b0);
        tick();
        send_beat(16'h2222, 16'h3333, 1'b0);
        tick();
        check("clr_partial_data", 32'(out_data), 32'd48);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_out_data", 32'(out_data), 32'd0);
        check("clr_out_beats", 32'(out_beats), 32'd0);
        check("clr_out_valid", {31'b0, out_valid}, 32'd0);
        send_beat(16'h1111, 16'h1111, 1'b1);
        tick();
        check("clr_new_valid", {31'b0, out_valid}, 32'd1);
        check("clr_new_data", 32'(out_data), 32'd4);
        check("clr_new_beats", 32'(out_beats), 32'd1);
        complete();

        // Asynchronous reset while COMPUTE is pending.
        send_beat(16'h2222, 16'h2222, 1'b0);
        tick();
        mul_ready = 1'b0;
        send_beat(16'h3333, 16'h3333, 1'b0);
        check("ar_mul_valid_before", {31'b0, mul_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_mul_valid", {31'b0, mul_valid}, 32'd0);
        check("ar_out_data", 32'(out_data), 32'd0);
        check("ar_out_beats", 32'(out_beats), 32'd0);
        #2 reset_n = 1'b1;
        mul_ready = 1'b1;
        tick();
        check("ar_in_ready", {31'b0, in_ready}, 32'd1);
        send_beat(16'h1111, 16'h1111, 1'b1);
        tick();
        check("ar_new_valid", {31'b0, out_valid}, 32'd1);
        check("ar_new_data", 32'(out_data), 32'd4);
        check("ar_new_beats", 32'(out_beats), 32'd1);
        complete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
